servo_cmd_uart_rx: RTL and testbench

- Serial command front end for the servo PWM stage; sits directly upstream of it.
- Receives 8N1 UART bytes (ASCII servo commands) from the host link.
- Presents each good byte with a one-cycle strobe; the byte feeds pulse-width scaling (1 ms + 1 ms*byte/256).
- Derives the level-sensitive run enable that drives the PWM stage's active input: 'G' starts it, 'S' stops it.

---
 rtl/servo_cmd_uart_rx.sv | 145 ++++++++++++++
 tb/tb_servo_cmd_uart_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_cmd_uart_rx.sv
// servo_cmd_uart_rx: 8N1 UART receiver for ASCII servo commands.
// Emits each good byte with a one-cycle strobe and derives the PWM run
// enable from the GO/STOP command characters.
module servo_cmd_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [7:0]  GO_CHAR      = 8'h47,
    parameter logic [7:0]  STOP_CHAR    = 8'h53
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       cmd_active,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             cmd_active_q, cmd_active_d;
    logic             rx_meta_q, rx_s_q;

    // State, datapath and synchroniser registers; rx sync flops reset to idle-high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            cmd_active_q <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            cmd_active_q <= cmd_active_d;
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
        end
    end

    // Next-state and datapath logic; the baud counter restarts on every state change.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q + CNT_W'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        cmd_active_d = cmd_active_q;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d = '0;
                    if (!rx_s_q) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d = '0;
                    if (rx_s_q) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                        if (shift_q == GO_CHAR) begin
                            cmd_active_d = 1'b1;
                        end else if (shift_q == STOP_CHAR) begin
                            cmd_active_d = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                baud_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign cmd_active = cmd_active_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_servo_cmd_uart_rx.sv
// Testbench for servo_cmd_uart_rx at 16 clocks per bit.
module tb_servo_cmd_uart_rx;

    localparam int unsigned CPB = 16;
    localparam logic [7:0] GO_C = 8'h47;
    localparam logic [7:0] ST_C = 8'h53;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       cmd_active;
    logic       busy;

    servo_cmd_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .GO_CHAR(GO_C),
        .STOP_CHAR(ST_C)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_err(frame_err),
        .cmd_active(cmd_active),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int dv_last_cyc = 0;
    int viol = 0;
    logic prev_dv = 1'b0;
    logic prev_fe = 1'b0;
    logic [7:0] obs_q[$];
    logic       obs_cmd_q[$];
    logic       model_cmd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe strobes away from the active edge.
    always @(negedge clk) begin
        if (data_valid) begin
            obs_q.push_back(data_out);
            obs_cmd_q.push_back(cmd_active);
            dv_cnt = dv_cnt + 1;
            dv_last_cyc = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if ((data_valid && frame_err) || (data_valid && prev_dv) || (frame_err && prev_fe))
            viol = viol + 1;
        prev_dv = data_valid;
        prev_fe = frame_err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (data_out !== 8'h00) begin n_mis++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_mis++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_mis++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (cmd_active !== 1'b0) begin n_mis++; $display("FAIL reset_cmd_active: got %b want 0", cmd_active); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single;
        int dv0, fe0, lat;
        logic [7:0] got;
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_byte(8'h55, 1'b1);
        repeat (5) @(negedge clk);
        n_cmp++; if (dv_cnt !== dv0 + 1) begin n_mis++; $display("FAIL single_dv_count: got %0d want %0d", dv_cnt - dv0, 1); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front(); void'(obs_cmd_q.pop_front());
            n_cmp++; if (got !== 8'h55) begin n_mis++; $display("FAIL single_byte: got %h want 55", got); end
        end
        lat = dv_last_cyc - fall_cyc;
        n_cmp++; if (lat < 154 || lat > 156) begin n_mis++; $display("FAIL single_latency: got %0d want 155+/-1", lat); end
        n_cmp++; if (fe_cnt !== fe0) begin n_mis++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt - fe0); end
        n_cmp++; if (data_out !== 8'h55) begin n_mis++; $display("FAIL single_data_out: got %h want 55", data_out); end
    endtask

    task automatic test_glitch;
        int dv0, fe0;
        dv0 = dv_cnt; fe0 = fe_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL glitch_busy: got %b want 0", busy); end
        repeat (30) @(negedge clk);
        n_cmp++; if (dv_cnt !== dv0) begin n_mis++; $display("FAIL glitch_dv: got %0d want 0", dv_cnt - dv0); end
        n_cmp++; if (fe_cnt !== fe0) begin n_mis++; $display("FAIL glitch_fe: got %0d want 0", fe_cnt - fe0); end
    endtask

    task automatic test_frame_err;
        int dv0, fe0;
        logic [7:0] got;
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_byte(8'hA3, 1'b0);
        repeat (100) @(negedge clk);
        n_cmp++; if (fe_cnt !== fe0 + 1) begin n_mis++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (dv_cnt !== dv0) begin n_mis++; $display("FAIL ferr_no_dv: got %0d want 0", dv_cnt - dv0); end
        n_cmp++; if (data_out !== 8'h55) begin n_mis++; $display("FAIL ferr_data_hold: got %h want 55", data_out); end
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h12, 1'b1);
        repeat (5) @(negedge clk);
        n_cmp++; if (dv_cnt !== dv0 + 1) begin n_mis++; $display("FAIL ferr_recover_dv: got %0d want 1", dv_cnt - dv0); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front(); void'(obs_cmd_q.pop_front());
            n_cmp++; if (got !== 8'h12) begin n_mis++; $display("FAIL ferr_recover_byte: got %h want 12", got); end
        end
        n_cmp++; if (cmd_active !== model_cmd) begin n_mis++; $display("FAIL ferr_cmd: got %b want %b", cmd_active, model_cmd); end
    endtask

    task automatic test_cmd_sequence;
        logic [7:0] seq [3];
        logic [7:0] got;
        logic       gcmd;
        seq[0] = 8'h47; seq[1] = 8'h41; seq[2] = 8'h53;
        for (int i = 0; i < 3; i++) begin
            send_byte(seq[i], 1'b1);
            repeat (3) @(negedge clk);
            if (seq[i] == GO_C) model_cmd = 1'b1;
            else if (seq[i] == ST_C) model_cmd = 1'b0;
            n_cmp++; if (obs_q.size() !== 1) begin n_mis++; $display("FAIL cmd_strobe_%0d: got %0d want 1", i, obs_q.size()); end
            if (obs_q.size() > 0) begin
                got = obs_q.pop_front(); gcmd = obs_cmd_q.pop_front();
                n_cmp++; if (got !== seq[i]) begin n_mis++; $display("FAIL cmd_byte_%0d: got %h want %h", i, got, seq[i]); end
                n_cmp++; if (gcmd !== model_cmd) begin n_mis++; $display("FAIL cmd_at_strobe_%0d: got %b want %b", i, gcmd, model_cmd); end
            end
            n_cmp++; if (cmd_active !== model_cmd) begin n_mis++; $display("FAIL cmd_level_%0d: got %b want %b", i, cmd_active, model_cmd); end
        end
    endtask

    task automatic test_reset_mid;
        int dv0;
        logic [7:0] got;
        send_byte(GO_C, 1'b1);
        repeat (3) @(negedge clk);
        void'(obs_q.pop_front()); void'(obs_cmd_q.pop_front());
        model_cmd = 1'b1;
        n_cmp++; if (cmd_active !== 1'b1) begin n_mis++; $display("FAIL rmid_pre_cmd: got %b want 1", cmd_active); end
        dv0 = dv_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_cmd = 1'b0;
        n_cmp++; if (data_out !== 8'h00) begin n_mis++; $display("FAIL rmid_data_out: got %h want 00", data_out); end
        n_cmp++; if (cmd_active !== 1'b0) begin n_mis++; $display("FAIL rmid_cmd_active: got %b want 0", cmd_active); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if ((data_valid | frame_err) !== 1'b0) begin n_mis++; $display("FAIL rmid_strobes: got %b%b want 00", data_valid, frame_err); end
        rst_n = 1'b1;
        repeat (130) @(negedge clk);
        n_cmp++; if (dv_cnt !== dv0) begin n_mis++; $display("FAIL rmid_no_dv: got %0d want 0", dv_cnt - dv0); end
        send_byte(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++; if (dv_cnt !== dv0 + 1) begin n_mis++; $display("FAIL rmid_next_dv: got %0d want 1", dv_cnt - dv0); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front(); void'(obs_cmd_q.pop_front());
            n_cmp++; if (got !== 8'h3C) begin n_mis++; $display("FAIL rmid_next_byte: got %h want 3c", got); end
        end
    endtask

    task automatic test_back_to_back;
        int dv0, fe0;
        logic [7:0] got;
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h80, 1'b1);
        repeat (5) @(negedge clk);
        n_cmp++; if (dv_cnt !== dv0 + 2) begin n_mis++; $display("FAIL b2b_dv_count: got %0d want 2", dv_cnt - dv0); end
        n_cmp++; if (fe_cnt !== fe0) begin n_mis++; $display("FAIL b2b_fe: got %0d want 0", fe_cnt - fe0); end
        if (obs_q.size() >= 2) begin
            got = obs_q.pop_front(); void'(obs_cmd_q.pop_front());
            n_cmp++; if (got !== 8'h01) begin n_mis++; $display("FAIL b2b_first: got %h want 01", got); end
            got = obs_q.pop_front(); void'(obs_cmd_q.pop_front());
            n_cmp++; if (got !== 8'h80) begin n_mis++; $display("FAIL b2b_second: got %h want 80", got); end
        end
        obs_q.delete(); obs_cmd_q.delete();
    endtask

    task automatic test_random;
        logic [7:0] b, got;
        logic       gcmd;
        int         r;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0) b = GO_C;
            else if (r == 1) b = ST_C;
            else b = 8'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_byte(b, 1'b1);
            repeat (3) @(negedge clk);
            if (b == GO_C) model_cmd = 1'b1;
            else if (b == ST_C) model_cmd = 1'b0;
            n_cmp++; if (obs_q.size() !== 1) begin n_mis++; $display("FAIL rand_strobe_%0d: got %0d want 1", i, obs_q.size()); end
            if (obs_q.size() > 0) begin
                got = obs_q.pop_front(); gcmd = obs_cmd_q.pop_front();
                n_cmp++; if (got !== b) begin n_mis++; $display("FAIL rand_byte_%0d: got %h want %h", i, got, b); end
                n_cmp++; if (gcmd !== model_cmd) begin n_mis++; $display("FAIL rand_cmd_%0d: got %b want %b", i, gcmd, model_cmd); end
            end
            obs_q.delete(); obs_cmd_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_cmd_sequence();
        test_reset_mid();
        test_back_to_back();
        test_random();
        n_cmp++; if (viol !== 0) begin n_mis++; $display("FAIL strobe_exclusive: got %0d violations want 0", viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
